shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the serialized word length in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has a word to send.
REQ-005 The block SHALL have port req0_data, input, WIDTH bits: requester 0 word.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: requester 0 word accepted this cycle when high together with req0_valid.
REQ-007 The block SHALL have ports req1_valid, req1_data and req1_ready, identical to REQ-004..006, for requester 1.
REQ-008 The block SHALL have port lsb_first, input, 1 bit: bit order, sampled only at acceptance (1 = LSB first).
REQ-009 The block SHALL have port sout, output, 1 bit: serial data.
REQ-010 The block SHALL have port frame, output, 1 bit: high for every cycle in which sout carries a valid bit.
REQ-011 The block SHALL have port owner, output, 1 bit: index of the requester whose word is in flight, held until the next grant.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE, the block SHALL assert exactly one ready: the ready of the arbitration winner, and only if that requester's valid is high.
REQ-015 Arbitration SHALL be round-robin: with a single valid, that requester wins; with both valid, the requester not served last wins.
REQ-016 On a rising edge with valid and ready both high, the block SHALL load the word and lsb_first into an internal WIDTH-bit shift register, latch owner, clear the bit counter and go to SHIFT.
REQ-017 In SHIFT, the block SHALL drive frame=1 and present one bit per cycle on sout: bit 0 first if lsb_first=1, else bit WIDTH-1 first.
REQ-018 The first bit SHALL appear on sout in the cycle immediately after acceptance.
REQ-019 After exactly WIDTH SHIFT cycles, the block SHALL go to DONE; the bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap.
REQ-020 In DONE, the block SHALL drive done=1, frame=0, sout=0 and both readies 0 for one cycle, update the round-robin pointer to the served requester, then return to IDLE.
REQ-021 Per-word occupancy SHALL be WIDTH+2 cycles from acceptance to the next possible acceptance.
REQ-022 Outside SHIFT, the block SHALL hold sout=0 and frame=0.
REQ-023 Both readies SHALL be 0 in SHIFT and DONE; valid or data changes during those states SHALL have no effect.
REQ-024 A requester SHALL hold valid and data stable until accepted; dropping valid before acceptance SHALL simply withdraw the request.
REQ-025 Changes on lsb_first after acceptance SHALL NOT affect the word in flight.

Reset
REQ-026 Asserting reset SHALL immediately, without a clock edge, force state=IDLE, shift register=0, bit counter=0, sout=0, frame=0, done=0, owner=0, readies=0, and set the round-robin pointer to favour requester 0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the word with no done pulse; after release, the next acceptance SHALL follow REQ-014..016 normally.

Structure
REQ-028 State encoding (IDLE/SHIFT/DONE) and the requester-index type SHALL be defined in shared package shift_reg_pkg.
REQ-029 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: two valids, last-served pointer; output: winner index and grant-valid); FSM, counter and shift register SHALL stay in shift_seq_ctrl.

Verification
REQ-030 Single requester, WIDTH=4: req0 sends 4'b1011 with lsb_first=1 -> sout = 1,1,0,1 on the 4 cycles after acceptance, frame high for those cycles, done on cycle 5, owner=0.
REQ-031 MSB first: req1 sends 4'b1011 with lsb_first=0 -> sout = 1,0,1,1, owner=1.
REQ-032 Contention: both valid continuously after reset, req0=4'hA, req1=4'h5 -> grants alternate 0,1,0,... with acceptances spaced exactly 6 cycles apart.
REQ-033 Stability under busy: toggling req1_data and lsb_first during req0's SHIFT -> sout is unchanged and req1_ready stays 0 until IDLE.
REQ-034 Reset after 2 bits of a word -> sout, frame and done are 0 immediately, no done pulse occurs, and the next grant after release goes to req0 when both are valid.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and requester index.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic req_idx_t;

    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_rr_arb2.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to the requester not served last.
module rr_arb2
    import shift_reg_pkg::*;
(
    input  logic     i_valid0,
    input  logic     i_valid1,
    input  req_idx_t i_last,
    output req_idx_t o_winner,
    output logic     o_gnt_vld
);

    always_comb begin
        o_winner  = REQ0;
        o_gnt_vld = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_winner = ~i_last;
        end else if (i_valid1) begin
            o_winner = REQ1;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Arbitrates two requesters and serializes the accepted word on sout, framed, with a done pulse.
module shift_seq_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             lsb_first,
    output logic             sout,
    output logic             frame,
    output logic             owner,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lsb;
    req_idx_t         r_owner;
    req_idx_t         r_last;
    req_idx_t         w_winner;
    logic             w_gnt_vld;
    logic             w_accept;
    logic [WIDTH-1:0] w_load_data;

    rr_arb2 u_arb (
        .i_valid0  (req0_valid),
        .i_valid1  (req1_valid),
        .i_last    (r_last),
        .o_winner  (w_winner),
        .o_gnt_vld (w_gnt_vld)
    );

    // Ready is gated by reset too so both readies drop the instant reset rises.
    assign w_accept    = (r_state == ST_IDLE) && w_gnt_vld && !reset;
    assign w_load_data = (w_winner == REQ1) ? req1_data : req0_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == LAST_BIT) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The counter stops at WIDTH-1, the cycle the last bit is on sout, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_lsb   <= 1'b0;
            r_owner <= REQ0;
            r_last  <= REQ1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= w_load_data;
                        r_lsb   <= lsb_first;
                        r_owner <= w_winner;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (r_lsb) begin
                        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                    end else begin
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt != LAST_BIT) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_last <= r_owner;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign req0_ready = w_accept && (w_winner == REQ0);
    assign req1_ready = w_accept && (w_winner == REQ1);
    assign frame      = (r_state == ST_SHIFT);
    assign sout       = frame && (r_lsb ? r_shreg[0] : r_shreg[WIDTH-1]);
    assign done       = (r_state == ST_DONE);
    assign owner      = r_owner;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at WIDTH=4 with hand-computed serial sequences.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_data = 4'h0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_data = 4'h0;
    logic       req1_ready;
    logic       lsb_first = 1'b0;
    logic       sout;
    logic       frame;
    logic       owner;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    shift_seq_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lsb_first  (lsb_first),
        .sout       (sout),
        .frame      (frame),
        .owner      (owner),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at negedge+1 of the first IDLE cycle after DONE.
    // bits lists the expected serial stream, first bit in bits[3].
    task automatic send_word(input string tag, input logic idx, input logic [3:0] d,
                             input logic lsb, input logic [3:0] bits, input bit disturb);
        if (idx) begin
            req1_valid = 1'b1; req1_data = d;
        end else begin
            req0_valid = 1'b1; req0_data = d;
        end
        lsb_first = lsb;
        #1;
        chk({tag, "_rdy_win"}, idx ? req1_ready : req0_ready, 1);
        chk({tag, "_rdy_lose"}, idx ? req0_ready : req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (disturb) begin
                req1_valid = 1'b1;
                req1_data  = 4'(i * 5 + 3);
                lsb_first  = ~lsb_first;
            end
            #1;
            chk({tag, "_frame"}, frame, 1);
            chk({tag, "_sout"}, sout, bits[3-i]);
            chk({tag, "_owner"}, owner, idx);
            chk({tag, "_done_early"}, done, 0);
            if (disturb) chk({tag, "_busy_rdy1"}, req1_ready, 0);
            @(negedge clk);
        end
        #1;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_frame"}, frame, 0);
        chk({tag, "_done_sout"}, sout, 0);
        chk({tag, "_done_rdy"}, {req0_ready, req1_ready}, 0);
        @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_frame"}, frame, 0);
    endtask

    initial begin
        logic gidx;
        bit   found;
        int   t_acc;
        int   t_prev;

        // Reset applies without a clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_sout", sout, 0);
        chk("rst_frame", frame, 0);
        chk("rst_done", done, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send_word("lsb_r0", 1'b0, 4'b1011, 1'b1, 4'b1101, 1'b0);
        @(negedge clk);
        send_word("msb_r1", 1'b1, 4'b1011, 1'b0, 4'b1011, 1'b0);
        @(negedge clk);
        // req1 pounds on valid/data/lsb_first during req0's word
        send_word("busy_r0", 1'b0, 4'hA, 1'b1, 4'b0101, 1'b1);
        chk("busy_idle_rdy1", req1_ready, 1);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("withdraw_frame", frame, 0);
        chk("withdraw_rdy", {req0_ready, req1_ready}, 0);

        // Abort a req1 word after two bits; pointer then says req1 served last = 0
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 4'b0110; lsb_first = 1'b1;
        #1 chk("abort_rdy1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1 chk("abort_bit0", sout, 0);
        @(negedge clk);
        #1 chk("abort_bit1", sout, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort_sout", sout, 0);
        chk("abort_frame", frame, 0);
        chk("abort_done", done, 0);
        chk("abort_owner", owner, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 chk("abort_no_done", done, 0);
        end
        req0_valid = 1'b1; req0_data = 4'hA;
        req1_valid = 1'b1; req1_data = 4'h5;
        #1;
        chk("abort_regrant0", req0_ready, 1);
        chk("abort_regrant1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Contention from a fresh reset: grants alternate, 6 cycles apart
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 4'hA;
        req1_valid = 1'b1; req1_data = 4'h5;
        lsb_first  = 1'b1;
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            found = 1'b0;
            gidx  = 1'b0;
            t_acc = 0;
            for (int k = 0; k < 10 && !found; k++) begin
                #1;
                chk("cont_one_rdy", req0_ready & req1_ready, 0);
                if (req0_ready || req1_ready) begin
                    found = 1'b1;
                    gidx  = req1_ready;
                    t_acc = cyc;
                end
                @(negedge clk);
            end
            chk("cont_found", found, 1);
            chk("cont_grant", gidx, n % 2);
            #1 chk("cont_owner", owner, n % 2);
            if (n > 0) chk("cont_gap", t_acc - t_prev, 6);
            t_prev = t_acc;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
